// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the writeback-port arbiter.
package wb_arb_pkg;
  localparam int XLEN_DEF       = 32;
  localparam int REG_ADDR_W_DEF = 5;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_W_DEF-1:0] rd;
    logic [XLEN_DEF-1:0]       data;
  } wb_req_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid at or above i_ptr, modulo N.
module rr_pick #(
  parameter  int N  = 3,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx
);
  int w_j;

  // Walk from the farthest candidate back to i_ptr so the nearest valid wins last.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (i_valid[w_j[PW-1:0]]) begin
        o_grant              = '0;
        o_grant[w_j[PW-1:0]] = 1'b1;
        o_idx                = w_j[PW-1:0];
      end
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter for the register-file write port with a registered output stage.
// Optional conflict counter enabled by defining WB_ARB_PERF_EN.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int XLEN       = XLEN_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*XLEN-1:0]       req_data,
  output logic [NUM_REQ-1:0]            req_ready,
`ifdef WB_ARB_PERF_EN
  output logic [31:0]                   conflict_cnt,
`endif
  output logic                          wr_en,
  output logic [REG_ADDR_W-1:0]         wr_addr,
  output logic [XLEN-1:0]               wr_data
);
  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]         r_ptr;
  logic [PW-1:0]         w_idx;
  logic [NUM_REQ-1:0]    w_grant;
  logic                  w_any;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [XLEN-1:0]       w_data;
  logic                  r_wr_en;
  logic [REG_ADDR_W-1:0] r_wr_addr;
  logic [XLEN-1:0]       r_wr_data;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign w_any     = |req_valid;
  assign req_ready = rst_n ? w_grant : '0;
  assign w_rd      = req_rd[int'(w_idx)*REG_ADDR_W +: REG_ADDR_W];
  assign w_data    = req_data[int'(w_idx)*XLEN +: XLEN];

  // x0 and flush only suppress the enable; the handshake and pointer still advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_any && (w_rd != '0) && !flush;
      if (w_any) begin
        r_ptr     <= PW'(rr_next(32'(w_idx), NUM_REQ));
        r_wr_addr <= w_rd;
        r_wr_data <= w_data;
      end
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

`ifdef WB_ARB_PERF_EN
  logic [31:0] r_conflict_cnt;
  logic        w_conflict;

  assign w_conflict = $countones(req_valid) >= 2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 r_conflict_cnt <= '0;
    else if (w_conflict && r_conflict_cnt != '1) r_conflict_cnt <= r_conflict_cnt + 32'd1;
  end

  assign conflict_cnt = r_conflict_cnt;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: driver pushes model expectations, negedge monitor checks.
module tb_wb_arbiter;
  import wb_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = REG_ADDR_W_DEF;
  localparam int DW = XLEN_DEF;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              flush = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*AW-1:0]   req_rd = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_ready;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
`ifdef WB_ARB_PERF_EN
  logic [31:0]       conflict_cnt;
`endif

  always #5 clk = ~clk;

  wb_arbiter #(.NUM_REQ(N), .XLEN(DW), .REG_ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_ready (req_ready),
`ifdef WB_ARB_PERF_EN
    .conflict_cnt (conflict_cnt),
`endif
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  typedef struct {
    logic [N-1:0]  ready;
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [31:0]   cnt;
  } exp_t;

  exp_t    q[$];
  int      n_chk = 0;
  int      n_fail = 0;

  // Reference model state
  int          m_ptr = 0;
  logic        m_en = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [31:0] m_cnt = '0;

  // Driver-side request view
  wb_req_t     cur[N];
  logic        d_rst = 1'b0;
  logic        d_flush = 1'b0;
  logic [N-1:0] pending = '0;

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    exp_t e;
    int   g;
    logic [N-1:0] v;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      v[i] = cur[i].valid;
      req_rd[i*AW +: AW]   = cur[i].rd;
      req_data[i*DW +: DW] = cur[i].data;
    end
    req_valid = v;
    flush     = d_flush;
    rst_n     = d_rst;
    if (!d_rst) begin
      m_ptr = 0; m_en = 0; m_addr = '0; m_data = '0; m_cnt = '0;
    end
    g = d_rst ? pick(v, m_ptr) : -1;
    e.ready = (g >= 0) ? N'(1 << g) : '0;
    e.en = m_en; e.addr = m_addr; e.data = m_data; e.cnt = m_cnt;
    q.push_back(e);
    if (d_rst) begin
      if ($countones(v) >= 2 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (g >= 0) begin
        m_en   = (cur[g].rd != 0) && !d_flush;
        m_addr = cur[g].rd;
        m_data = cur[g].data;
        m_ptr  = (g + 1) % N;
      end else begin
        m_en = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) pending[i] = v[i] && (g != i) && d_rst;
  endtask

  task automatic set_src(input int i, input logic vl, input logic [AW-1:0] rd, input logic [DW-1:0] dat);
    cur[i].valid = vl; cur[i].rd = rd; cur[i].data = dat;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) set_src(i, 1'b0, '0, '0);
  endtask

  // Monitor: checks every cycle's outputs against the queued expectation
  int waitc[N];
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("req_ready", 64'(req_ready), 64'(e.ready));
      chk("wr_en", 64'(wr_en), 64'(e.en));
      chk("wr_addr", 64'(wr_addr), 64'(e.addr));
      chk("wr_data", 64'(wr_data), 64'(e.data));
      chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      chk("ready_implies_valid", 64'(req_ready & ~req_valid), 64'd0);
`ifdef WB_ARB_PERF_EN
      chk("conflict_cnt", 64'(conflict_cnt), 64'(e.cnt));
`endif
      for (int i = 0; i < N; i++) begin
        if (rst_n && req_valid[i] && !req_ready[i]) waitc[i] = waitc[i] + 1;
        else waitc[i] = 0;
        if (rst_n && req_valid[i]) chk("no_starve", 64'(waitc[i] < N), 64'd1);
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) waitc[i] = 0;
    clear_all();
    #2 rst_n = 1'b0;

    // Reset held with all sources requesting
    d_rst = 1'b0;
    for (int i = 0; i < N; i++) set_src(i, 1'b1, AW'(i + 4), DW'(32'h1000 + i));
    repeat (5) step();

    // Single source
    d_rst = 1'b1;
    clear_all(); step();
    set_src(1, 1'b1, 5'd7, 32'hDEADBEEF); step();
    clear_all(); step();

    // Contention from a freshly reset pointer
    d_rst = 1'b0; step();
    d_rst = 1'b1;
    for (int i = 0; i < N; i++) set_src(i, 1'b1, AW'(i + 1), DW'(32'hA000 + i));
    repeat (6) step();

    // Wrap: src2 alone then src0 alone
    clear_all(); set_src(2, 1'b1, 5'd9, 32'h2222_0002); step();
    clear_all(); set_src(0, 1'b1, 5'd10, 32'h0000_0A0A); step();

    // x0 write and flushed write
    clear_all(); set_src(0, 1'b1, 5'd0, 32'h1234_5678); step();
    clear_all(); set_src(1, 1'b1, 5'd3, 32'hCAFE_F00D); d_flush = 1'b1; step();
    d_flush = 1'b1; clear_all(); step();
    d_flush = 1'b0; step();

    // Randomised traffic honouring hold-until-ready
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pending[i]) begin
          cur[i].valid = ($urandom_range(0, 9) < 6);
          cur[i].rd    = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
          cur[i].data  = $urandom;
        end
      end
      d_flush = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 999) == 0) begin
        d_rst = 1'b0; step(); d_rst = 1'b1;
      end else begin
        step();
      end
    end

    clear_all(); d_flush = 1'b0; step();
    repeat (2) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
